// File: rtl/microbot_pkg.sv
// Shared definitions for the microbot motor driver.
//   chan_state_t : per-channel FSM state encoding
//   CMD_*        : 2-bit per-channel direction command codes {d,i}
//   MOTOR_*      : bit positions inside the 4-bit motors_cmd / pwm_out vectors
//   DEAD_W       : width of the dead-time counter (holds 1..255)
//   is_move      : true for a legal drive command (FWD or REV)
package microbot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DEAD  = 2'b01,
    ST_DRIVE = 2'b10
  } chan_state_t;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_REV  = 2'b01;
  localparam logic [1:0] CMD_FWD  = 2'b10;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  localparam int MOTOR_A_D = 3;
  localparam int MOTOR_A_I = 2;
  localparam int MOTOR_B_D = 1;
  localparam int MOTOR_B_I = 0;

  localparam int DEAD_W = 8;

  function automatic logic is_move(input logic [1:0] cmd);
    return (cmd == CMD_FWD) || (cmd == CMD_REV);
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: IDLE/DEAD/DRIVE FSM, dead-time counter, duty
// soft-start ramp and sticky illegal-command fault.
// Optional build macro: MOTOR_BRAKE_EN (brake flag after a STOP from DRIVE).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   cmd        : decoded {d,i} command for this channel (STOP when disabled)
//   wrap       : high in the cycle the shared PWM counter is at its maximum
//   state      : current FSM state (also serves as the debug view)
//   dir        : latched direction (CMD_FWD / CMD_REV, CMD_STOP when idle)
//   duty       : current duty value compared against the PWM counter
//   drive_ok   : in DRIVE and this cycle's command keeps it there
//   brake      : IDLE brake flag (constant 0 without MOTOR_BRAKE_EN)
//   fault      : sticky, set by an illegal {d,i}=11 command
module motor_pwm_channel
  import microbot_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 16,
  parameter int RAMP_STEP   = 32,
  parameter int DUTY_MAX    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          cmd,
  input  logic                wrap,
  output chan_state_t         state,
  output logic [1:0]          dir,
  output logic [PWM_BITS-1:0] duty,
  output logic                drive_ok,
  output logic                brake,
  output logic                fault
);

  logic [DEAD_W-1:0] dead_cnt;
  logic              move;
  // One extra bit so the ramp sum cannot wrap before saturation.
  logic [PWM_BITS:0] duty_sum;

  assign move     = is_move(cmd);
  assign duty_sum = {1'b0, duty} + (PWM_BITS+1)'(RAMP_STEP);
  // Any command other than the latched direction makes DRIVE exit this cycle,
  // so the output stage uses this to drop the legs with one cycle of latency.
  assign drive_ok = (state == ST_DRIVE) && (cmd == dir);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      dir      <= CMD_STOP;
      dead_cnt <= '0;
      duty     <= '0;
      fault    <= 1'b0;
    end else begin
      if (cmd == CMD_ILL) fault <= 1'b1;
      case (state)
        ST_IDLE: begin
          duty <= '0;
          if (move) begin
            dir      <= cmd;
            dead_cnt <= DEAD_W'(DEAD_CYCLES);
            state    <= ST_DEAD;
          end
        end
        ST_DEAD: begin
          duty <= '0;
          if (!move) begin
            state <= ST_IDLE;
            dir   <= CMD_STOP;
          end else if (cmd != dir) begin
            dir      <= cmd;
            dead_cnt <= DEAD_W'(DEAD_CYCLES);
          end else if (dead_cnt == DEAD_W'(1)) begin
            // Counter reaches 0 here: DEAD_CYCLES cycles have been spent in DEAD.
            dead_cnt <= '0;
            state    <= ST_DRIVE;
          end else begin
            dead_cnt <= dead_cnt - DEAD_W'(1);
          end
        end
        ST_DRIVE: begin
          if (!move) begin
            state <= ST_IDLE;
            dir   <= CMD_STOP;
            duty  <= '0;
          end else if (cmd != dir) begin
            state    <= ST_DEAD;
            dir      <= cmd;
            dead_cnt <= DEAD_W'(DEAD_CYCLES);
            duty     <= '0;
          end else if (wrap) begin
            duty <= (duty_sum > (PWM_BITS+1)'(DUTY_MAX)) ? PWM_BITS'(DUTY_MAX)
                                                         : duty_sum[PWM_BITS-1:0];
          end
        end
        default: begin
          state <= ST_IDLE;
          dir   <= CMD_STOP;
          duty  <= '0;
        end
      endcase
    end
  end

`ifdef MOTOR_BRAKE_EN
  // Set when DRIVE is left on a STOP; cleared on the IDLE->DEAD transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      brake <= 1'b0;
    end else if ((state == ST_DRIVE) && !move) begin
      brake <= 1'b1;
    end else if ((state == ST_IDLE) && move) begin
      brake <= 1'b0;
    end
  end
`else
  assign brake = 1'b0;
`endif

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor PWM driver: takes the 4-bit direction command and drives two
// independent H-bridge channels with soft-started PWM and dead-time.
// Optional build macro: MOTOR_BRAKE_EN (IDLE after STOP from DRIVE outputs 11).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en         : 0 forces both channels to STOP
//   motors_cmd : {A_d, A_i, B_d, B_i}
//   pwm_out    : registered H-bridge leg drives, same bit order as motors_cmd
//   busy       : registered per channel ([1]=A, [0]=B), 1 while DEAD or DRIVE
//   fault      : sticky per channel, illegal {d,i}=11 seen since reset
module motor_pwm_driver
  import microbot_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 16,
  parameter int RAMP_STEP   = 32,
  parameter int DUTY_MAX    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] motors_cmd,
  output logic [3:0] pwm_out,
  output logic [1:0] busy,
  output logic [1:0] fault
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                wrap;
  logic [1:0]          cmd_a, cmd_b;

  chan_state_t         state_a, state_b;
  logic [1:0]          dir_a, dir_b;
  logic [PWM_BITS-1:0] duty_a, duty_b;
  logic                drive_ok_a, drive_ok_b;
  logic                brake_a, brake_b;
  logic                fault_a, fault_b;
  logic [1:0]          legs_a, legs_b;

  assign wrap  = &pwm_cnt;
  assign cmd_a = en ? motors_cmd[MOTOR_A_D:MOTOR_A_I] : CMD_STOP;
  assign cmd_b = en ? motors_cmd[MOTOR_B_D:MOTOR_B_I] : CMD_STOP;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  motor_pwm_channel #(
    .PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES),
    .RAMP_STEP(RAMP_STEP), .DUTY_MAX(DUTY_MAX)
  ) u_chan_a (
    .clk(clk), .reset(reset), .cmd(cmd_a), .wrap(wrap),
    .state(state_a), .dir(dir_a), .duty(duty_a),
    .drive_ok(drive_ok_a), .brake(brake_a), .fault(fault_a)
  );

  motor_pwm_channel #(
    .PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES),
    .RAMP_STEP(RAMP_STEP), .DUTY_MAX(DUTY_MAX)
  ) u_chan_b (
    .clk(clk), .reset(reset), .cmd(cmd_b), .wrap(wrap),
    .state(state_b), .dir(dir_b), .duty(duty_b),
    .drive_ok(drive_ok_b), .brake(brake_b), .fault(fault_b)
  );

  // Leg selection. Only one leg can be active from DRIVE; the 11 pattern is
  // reachable only through the brake flag, which exists only in IDLE.
  always_comb begin
    legs_a = 2'b00;
    if (drive_ok_a && (pwm_cnt < duty_a)) legs_a = (dir_a == CMD_FWD) ? 2'b10 : 2'b01;
    else if ((state_a == ST_IDLE) && brake_a) legs_a = 2'b11;
  end

  always_comb begin
    legs_b = 2'b00;
    if (drive_ok_b && (pwm_cnt < duty_b)) legs_b = (dir_b == CMD_FWD) ? 2'b10 : 2'b01;
    else if ((state_b == ST_IDLE) && brake_b) legs_b = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= '0;
      busy    <= '0;
    end else begin
      pwm_out <= {legs_a, legs_b};
      busy    <= {state_a != ST_IDLE, state_b != ST_IDLE};
    end
  end

  assign fault = {fault_a, fault_b};

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver with default parameters.
module tb_motor_pwm_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] motors_cmd;
  logic [3:0] pwm_out;
  logic [1:0] busy;
  logic [1:0] fault;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];

  motor_pwm_driver dut (
    .clk(clk), .reset(reset), .en(en), .motors_cmd(motors_cmd),
    .pwm_out(pwm_out), .busy(busy), .fault(fault)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver / checker tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] cmd;
    int         cycles;
    logic [3:0] exp_pwm;
    logic [1:0] exp_busy;
    logic [1:0] exp_fault;
    string      name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int ca, cb, ci, cbad, found;
    logic [31:0] e;

    vecs[0]  = '{1'b0, 1'b1, 4'b1100, 1,  4'b0000, 2'b11, 2'b10, "ill_a_stop"};
    vecs[1]  = '{1'b0, 1'b1, 4'b1100, 1,  4'b0000, 2'b00, 2'b10, "ill_a_idle"};
    vecs[2]  = '{1'b0, 1'b1, 4'b1000, 1,  4'b0000, 2'b00, 2'b10, "fault_sticky0"};
    vecs[3]  = '{1'b0, 1'b1, 4'b1000, 1,  4'b0000, 2'b10, 2'b10, "fault_sticky1"};
    vecs[4]  = '{1'b0, 1'b1, 4'b0011, 1,  4'b0000, 2'b10, 2'b11, "ill_b"};
    vecs[5]  = '{1'b0, 1'b1, 4'b0000, 1,  4'b0000, 2'b00, 2'b11, "both_idle"};
    vecs[6]  = '{1'b1, 1'b1, 4'b1010, 1,  4'b0000, 2'b00, 2'b00, "reset_mid"};
    vecs[7]  = '{1'b0, 1'b0, 4'b1010, 2,  4'b0000, 2'b00, 2'b00, "en_low_idle"};
    vecs[8]  = '{1'b0, 1'b1, 4'b0101, 1,  4'b0000, 2'b00, 2'b00, "rev_entry"};
    vecs[9]  = '{1'b0, 1'b1, 4'b0101, 1,  4'b0000, 2'b11, 2'b00, "rev_dead"};
    vecs[10] = '{1'b0, 1'b1, 4'b0101, 15, 4'b0000, 2'b11, 2'b00, "rev_dead_end"};
    vecs[11] = '{1'b0, 1'b1, 4'b0101, 1,  4'b0000, 2'b11, 2'b00, "rev_drive_d0"};
    vecs[12] = '{1'b0, 1'b1, 4'b1001, 1,  4'b0000, 2'b11, 2'b00, "a_flip_b_hold"};

    // ---------------- reset ----------------
    reset = 1'b1; en = 1'b1; motors_cmd = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_pwm", 32'(pwm_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_fault", 32'(fault), 0);
    end

    // First edge after release enters DEAD; busy shows it one cycle later.
    reset = 1'b0;
    step(1);
    check("rel_pwm", 32'(pwm_out), 0);
    check("rel_busy", 32'(busy), 0);
    step(1);
    check("dead_busy", 32'(busy), 32'h3);

    // Dead time plus the partial first period: no leg may rise.
    cbad = 0;
    for (int i = 0; i < 254; i++) begin
      step(1);
      if (pwm_out != 4'b0000) cbad++;
    end
    check("pre_ramp_zero", 32'(cbad), 0);

    // ---------------- soft-start ramp, 9 full periods ----------------
    for (int p = 0; p < 9; p++) begin
      e = 32'(32 * (p + 1));
      if (e > 255) e = 255;
      exp_q.push_back(e);
    end
    for (int p = 0; p < 9; p++) begin
      ca = 0; cb = 0; ci = 0;
      for (int i = 0; i < 256; i++) begin
        step(1);
        ca += int'(pwm_out[3]);
        cb += int'(pwm_out[1]);
        ci += int'(pwm_out[2] | pwm_out[0]);
      end
      e = exp_q.pop_front();
      check("ramp_a_high", 32'(ca), e);
      check("ramp_b_high", 32'(cb), e);
      check("ramp_i_legs", 32'(ci), 0);
    end

    // ---------------- A reversal while B keeps driving ----------------
    motors_cmd = 4'b0110;
    step(1);
    check("rev_a_off", 32'(pwm_out), 32'h2);
    cbad = 0; cb = 0;
    for (int i = 0; i < 255; i++) begin
      step(1);
      if (pwm_out[3:2] != 2'b00) cbad++;
      cb += int'(pwm_out[1]);
    end
    check("rev_dead_gap", 32'(cbad), 0);
    check("rev_b_high", 32'(cb), 254);
    ca = 0; ci = 0; cb = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      ca += int'(pwm_out[2]);
      ci += int'(pwm_out[3]);
      cb += int'(pwm_out[1]);
    end
    check("rev_a_ramp", 32'(ca), 32);
    check("rev_a_d_leg", 32'(ci), 0);
    check("rev_b_full", 32'(cb), 255);

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < 13; v++) begin
      reset = vecs[v].rst; en = vecs[v].en; motors_cmd = vecs[v].cmd;
      step(vecs[v].cycles);
      check({vecs[v].name, "_pwm"},   32'(pwm_out), 32'(vecs[v].exp_pwm));
      check({vecs[v].name, "_busy"},  32'(busy),    32'(vecs[v].exp_busy));
      check({vecs[v].name, "_fault"}, 32'(fault),   32'(vecs[v].exp_fault));
    end

    // ---------------- en drop during drive ----------------
    motors_cmd = 4'b1010; en = 1'b1;
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      step(1);
      if (pwm_out != 4'b0000) found = 1;
    end
    check("en_pre_drive", 32'(found), 1);
    check("en_pre_i_legs", 32'(pwm_out & 4'b0101), 0);
    en = 1'b0;
    step(1);
    check("en_off_pwm", 32'(pwm_out), 0);
    step(1);
    check("en_off_busy", 32'(busy), 0);
    check("en_off_pwm2", 32'(pwm_out), 0);
    en = 1'b1;
    step(1);
    check("en_on_busy", 32'(busy), 0);
    cbad = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (pwm_out != 4'b0000 || busy != 2'b11) cbad++;
    end
    check("en_on_dead", 32'(cbad), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
Downstream stage of the microbot navigation FSM. It consumes the 4-bit motor direction command and drives the two H-bridge channels (A, B) with PWM. It soft-starts the duty cycle, inserts dead-time on every direction change, and flags illegal commands. Its outputs go straight to the chip's dedicated output pins.

Parameters:
PWM_BITS, 8, width of the shared PWM counter; period = 2^PWM_BITS cycles
DEAD_CYCLES, 16, cycles with both legs low before any drive starts (range 1..255)
RAMP_STEP, 32, duty increment applied at each PWM period wrap
DUTY_MAX, 255, duty saturation value (must be < 2^PWM_BITS)

Ports:
clk  input  1  system clock (single clock domain)
reset  input  1  synchronous, active-high reset
en  input  1  block enable; 0 forces both channels to the stop command
motors_cmd  input  4  direction command {A_d, A_i, B_d, B_i} = bits [3:0]
pwm_out  output  4  H-bridge inputs, same bit order as motors_cmd
busy  output  2  per channel ([1]=A, [0]=B): 1 while in DEAD or DRIVE
fault  output  2  sticky per channel: illegal {d,i}=11 command seen

Behaviour:
- Reset: pwm_out=0, busy=0, fault=0, PWM counter=0, both channels in IDLE with duty=0.
- Shared PWM counter: free-running 0..2^PWM_BITS-1, wraps to 0. "Wrap" is the cycle where the counter equals its maximum.
- Per-channel command decode of {d,i}: 10 = FWD, 01 = REV, 00 = STOP, 11 = illegal. Illegal is treated as STOP and sets fault in the same cycle. en=0 means STOP.
- Per-channel FSM, states IDLE, DEAD, DRIVE:
  - IDLE: both legs 0, duty=0. On FWD or REV: latch dir, load dead counter with DEAD_CYCLES, go to DEAD.
  - DEAD: both legs 0; dead counter decrements each cycle.
    - STOP returns to IDLE.
    - Opposite dir relatches dir and reloads the counter.
    - Same dir: when the counter reaches 0 (exactly DEAD_CYCLES cycles spent in DEAD), go to DRIVE with duty=0.
  - DRIVE: active leg (d for FWD, i for REV) = (pwm_cnt < duty); the other leg is 0.
    - At each wrap: duty = min(duty + RAMP_STEP, DUTY_MAX), computed with one extra bit so it cannot overflow.
    - STOP goes to IDLE.
    - Opposite dir goes to DEAD with the new dir and duty=0.
    - Same dir stays in DRIVE.
- Simultaneous wrap and state exit: the exit wins and duty resets.
- Outputs are registered: pwm_out and busy in cycle N+1 reflect state, duty and pwm_cnt at cycle N. Command-to-output latency is 1 cycle for STOP.
- Never permitted: both legs of a channel high (except the brake case in Optional Feature). No drive without a full DEAD_CYCLES gap after IDLE or a reversal.
- Reset mid-operation: everything returns to reset values on the next edge. fault clears only on reset.
- Channels A and B are fully independent; only the PWM counter is shared.

Optional Feature:
MOTOR_BRAKE_EN.
- Defined: a channel leaving DRIVE on STOP enters IDLE with a brake flag set, and outputs {d,i}=11 (H-bridge slow-decay brake). The flag clears when the channel enters DEAD or on reset, and DEAD outputs 00 as before. IDLE entered from reset or from DEAD outputs 00.
- Undefined: IDLE always outputs 00 and the flag logic is absent.

Decomposition:
- Package microbot_pkg holds:
  - channel state encoding (IDLE=2'b00, DEAD=2'b01, DRIVE=2'b10);
  - command codes (CMD_STOP=2'b00, CMD_REV=2'b01, CMD_FWD=2'b10, CMD_ILL=2'b11);
  - bit-index constants MOTOR_A_D=3, MOTOR_A_I=2, MOTOR_B_D=1, MOTOR_B_I=0.
- Sub-module motor_pwm_channel (FSM, dead counter, duty ramp, fault) is instantiated twice.
- The top level holds the PWM counter, command split and output registers.

Test Plan:
- Reset held 3 cycles with motors_cmd=4'b1010 -> pwm_out=0, busy=0, fault=0 throughout; first DEAD cycle occurs on the first edge after reset deasserts.
- motors_cmd=4'b1010, defaults -> pwm_out=0 for 16 cycles after entry to DEAD. The partial first period stays low. After the first wrap, pwm_out[3] and pwm_out[1] are high for 32 of every 256 cycles, then 64, 96 and so on, saturating at 255/256 from the 8th wrap. Bits [2] and [0] stay 0.
- In DRIVE, switch A to REV (4'b0110) -> pwm_out[3] low on the next cycle, both A legs low for 16 cycles, then pwm_out[2] ramps from duty 0. B is unaffected.
- Command 4'b1100 -> fault[1]=1 and channel A goes to IDLE (outputs 0). Returning to 4'b1000 leaves fault[1]=1 until reset.
- en=0 during DRIVE -> both channels reach IDLE and pwm_out=0 within 1 cycle. en=1 again -> full 16-cycle DEAD before drive resumes.
- With MOTOR_BRAKE_EN: DRIVE FWD then 4'b0000 -> pwm_out=4'b1111 until the next FWD, which gives 0000 for 16 cycles and then the ramp.
